// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a direct-mapped instruction cache.
//
// Owns the fetch PC and pushes at most one instruction per cycle into the
// instruction queue while the cache hits. On a miss a single word request is
// raised to the memory controller and held until it completes; the returned
// word is written into the cache and, when possible, forwarded straight to
// the queue. Redirects from branch/commit logic replace the PC at any time.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (low = freeze)
//   iIO_buffer_full   freeze, same effect as rdy low
//   oMC_en, oMC_addr  level-held word request to the memory controller
//   iMC_done,iMC_inst completion pulse and returned instruction
//   iJUMP_en,iJUMP_pc redirect pulse and target
//   iIQ_full          instruction queue cannot accept this cycle
//   oIQ_en,oIQ_inst,  one-cycle push into the instruction queue
//   oIQ_pc
// ---------------------------------------------------------------------------
module ifetch #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iIO_buffer_full,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst,
    input  logic        iJUMP_en,
    input  logic [31:0] iJUMP_pc,
    input  logic        iIQ_full,
    output logic        oIQ_en,
    output logic [31:0] oIQ_inst,
    output logic [31:0] oIQ_pc
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic        mc_en_reg, mc_en_next;
    logic [31:0] mc_addr_reg, mc_addr_next;
    logic        iq_en_reg, iq_en_next;
    logic [31:0] iq_inst_reg, iq_inst_next;
    logic [31:0] iq_pc_reg, iq_pc_next;

    // Cache storage: valid bits need reset, tag/data do not.
    logic            valid_reg [LINES];
    logic [TAGW-1:0] tag_mem   [LINES];
    logic [31:0]     data_mem  [LINES];

    logic            active;
    logic [IDX-1:0]  pc_idx;
    logic [TAGW-1:0] pc_tag;
    logic            hit;
    logic            fill_en;
    logic [IDX-1:0]  fill_idx;
    logic [TAGW-1:0] fill_tag;

    assign active   = rdy && !iIO_buffer_full;
    assign pc_idx   = pc_reg[IDX+1:2];
    assign pc_tag   = pc_reg[31:IDX+2];
    assign hit      = valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);

    // Fills always target the outstanding request, never the current PC,
    // since the PC may have been redirected while the request was in flight.
    assign fill_idx = req_addr_reg[IDX+1:2];
    assign fill_tag = req_addr_reg[31:IDX+2];

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        mc_en_next    = mc_en_reg;
        mc_addr_next  = mc_addr_reg;
        iq_en_next    = 1'b0;
        iq_inst_next  = iq_inst_reg;
        iq_pc_next    = iq_pc_reg;
        fill_en       = 1'b0;

        if (active) begin
            case (state_reg)
                IDLE: begin
                    if (iJUMP_en) begin
                        pc_next = iJUMP_pc;
                    end else if (iIQ_full) begin
                        pc_next = pc_reg;
                    end else if (hit) begin
                        iq_en_next   = 1'b1;
                        iq_inst_next = data_mem[pc_idx];
                        iq_pc_next   = pc_reg;
                        pc_next      = pc_reg + 32'd4;
                    end else begin
                        req_addr_next = pc_reg;
                        mc_en_next    = 1'b1;
                        mc_addr_next  = pc_reg;
                        state_next    = MISS;
                    end
                end

                MISS: begin
                    if (iMC_done) begin
                        fill_en    = 1'b1;
                        mc_en_next = 1'b0;
                        state_next = IDLE;
                    end
                    if (iJUMP_en) begin
                        pc_next = iJUMP_pc;
                        // The controller cannot abort, so keep the request
                        // up and discard its data once it arrives.
                        if (!iMC_done) begin
                            state_next = DRAIN;
                        end
                    end else if (iMC_done && !iIQ_full) begin
                        iq_en_next   = 1'b1;
                        iq_inst_next = iMC_inst;
                        iq_pc_next   = req_addr_reg;
                        pc_next      = req_addr_reg + 32'd4;
                    end
                    // Done while the queue is full: PC stays on the missed
                    // address and the next IDLE cycle hits the new line.
                end

                DRAIN: begin
                    if (iJUMP_en) begin
                        pc_next = iJUMP_pc;
                    end
                    if (iMC_done) begin
                        fill_en    = 1'b1;
                        mc_en_next = 1'b0;
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= 32'd0;
            req_addr_reg <= 32'd0;
            mc_en_reg    <= 1'b0;
            mc_addr_reg  <= 32'd0;
            iq_en_reg    <= 1'b0;
            iq_inst_reg  <= 32'd0;
            iq_pc_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            mc_en_reg    <= mc_en_next;
            mc_addr_reg  <= mc_addr_next;
            iq_en_reg    <= iq_en_next;
            iq_inst_reg  <= iq_inst_next;
            iq_pc_reg    <= iq_pc_next;
        end
    end

    // Per-line valid bits.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (fill_idx == IDX'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data arrays: written on fill only, no reset needed because
    // the valid bit gates every lookup.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iMC_inst;
        end
    end

    assign oMC_en   = mc_en_reg;
    assign oMC_addr = mc_addr_reg;
    assign oIQ_en   = iq_en_reg;
    assign oIQ_inst = iq_inst_reg;
    assign oIQ_pc   = iq_pc_reg;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- scoreboard bench for ifetch.
//
// A behavioural model (address-keyed cache, plain mode variable) predicts the
// complete output picture for each cycle and queues it; an independent
// monitor on the falling edge pops and compares. Stimulus mixes directed
// scenarios with randomized redirects, queue-full and freeze cycles; a
// memory model answers requests after a random latency with 0x13 + addr.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iIO_buffer_full;
    logic        oMC_en;
    logic [31:0] oMC_addr;
    logic        iMC_done;
    logic [31:0] iMC_inst;
    logic        iJUMP_en;
    logic [31:0] iJUMP_pc;
    logic        iIQ_full;
    logic        oIQ_en;
    logic [31:0] oIQ_inst;
    logic [31:0] oIQ_pc;

    ifetch #(.LINES(LINES)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iIO_buffer_full (iIO_buffer_full),
        .oMC_en          (oMC_en),
        .oMC_addr        (oMC_addr),
        .iMC_done        (iMC_done),
        .iMC_inst        (iMC_inst),
        .iJUMP_en        (iJUMP_en),
        .iJUMP_pc        (iJUMP_pc),
        .iIQ_full        (iIQ_full),
        .oIQ_en          (oIQ_en),
        .oIQ_inst        (oIQ_inst),
        .oIQ_pc          (oIQ_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit          mc_en;
        logic [31:0] mc_addr;
        bit          iq_en;
        logic [31:0] iq_inst;
        logic [31:0] iq_pc;
    } exp_t;

    exp_t q_exp[$];

    localparam int M_FETCH = 0;   // looking up / streaming
    localparam int M_WAIT  = 1;   // own request outstanding, result wanted
    localparam int M_DRAIN = 2;   // request outstanding, result discarded

    int          m_mode;
    logic [31:0] m_pc, m_req, m_mc_addr, m_iq_inst, m_iq_pc;
    bit          m_mc_en, m_iq_en;
    logic [31:0] line_addr [int];   // full word address held by each line
    logic [31:0] line_data [int];

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
        line_addr[line_of(a)] = a;
        line_data[line_of(a)] = d;
    endtask

    task automatic m_push(input logic [31:0] a, input logic [31:0] d);
        m_iq_en   = 1'b1;
        m_iq_pc   = a;
        m_iq_inst = d;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_FETCH; m_pc = 0; m_req = 0;
            m_mc_en = 0; m_mc_addr = 0; m_iq_en = 0; m_iq_inst = 0; m_iq_pc = 0;
            line_addr.delete();
            line_data.delete();
            q_exp.delete();
        end else begin
            m_iq_en = 1'b0;
            if (rdy && !iIO_buffer_full) begin
                if (m_mode == M_FETCH) begin
                    if (iJUMP_en) begin
                        m_pc = iJUMP_pc;
                    end else if (!iIQ_full) begin
                        if (line_addr.exists(line_of(m_pc)) && line_addr[line_of(m_pc)] == m_pc) begin
                            m_push(m_pc, line_data[line_of(m_pc)]);
                            m_pc = m_pc + 4;
                        end else begin
                            m_req = m_pc; m_mc_en = 1; m_mc_addr = m_pc; m_mode = M_WAIT;
                        end
                    end
                end else if (m_mode == M_WAIT) begin
                    if (iMC_done) begin
                        m_fill(m_req, iMC_inst);
                        m_mc_en = 0;
                        m_mode  = M_FETCH;
                        if (iJUMP_en) m_pc = iJUMP_pc;
                        else if (!iIQ_full) begin
                            m_push(m_req, iMC_inst);
                            m_pc = m_req + 4;
                        end
                    end else if (iJUMP_en) begin
                        m_pc = iJUMP_pc;
                        m_mode = M_DRAIN;
                    end
                end else begin
                    if (iJUMP_en) m_pc = iJUMP_pc;
                    if (iMC_done) begin
                        m_fill(m_req, iMC_inst);
                        m_mc_en = 0;
                        m_mode  = M_FETCH;
                    end
                end
            end
        end
        q_exp.push_back('{m_mc_en, m_mc_addr, m_iq_en, m_iq_inst, m_iq_pc});
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic prev_mc_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("mc_en",   {31'd0, oMC_en}, {31'd0, e.mc_en});
            chk("mc_addr", oMC_addr, e.mc_addr);
            chk("iq_en",   {31'd0, oIQ_en}, {31'd0, e.iq_en});
            chk("iq_inst", oIQ_inst, e.iq_inst);
            chk("iq_pc",   oIQ_pc,   e.iq_pc);
            if (oIQ_en)
                $display("push    pc=%h inst=%h", oIQ_pc, oIQ_inst);
            if (oMC_en && !prev_mc_en)
                $display("request addr=%h", oMC_addr);
        end
        prev_mc_en = oMC_en;
    end

    // ------------------------------------------------------------------
    // Stimulus and memory controller model
    // ------------------------------------------------------------------
    int mem_cnt  = 0;
    bit mem_just = 0;

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0020;
            2: return 32'h0000_0040;
            3: return 32'h0000_0100;
            4: return 32'h0000_1000;
            default: return 32'($urandom_range(0, 511)) << 2;
        endcase
    endfunction

    // Advance one cycle, then drive this cycle's inputs.
    task automatic cycle(input int pj, input int pf, input int pz);
        @(posedge clk);
        #1;
        mem_just = iMC_done;
        iMC_done = 1'b0;
        iMC_inst = $urandom;
        if (oMC_en && !mem_just) begin
            if (mem_cnt == 0) mem_cnt = $urandom_range(1, 5);
            mem_cnt--;
            if (mem_cnt == 0) begin
                iMC_done = 1'b1;
                iMC_inst = 32'h0000_0013 + oMC_addr;
            end
        end
        iJUMP_en        = ($urandom_range(0, 99) < pj);
        iJUMP_pc        = pick_target();
        iIQ_full        = ($urandom_range(0, 99) < pf);
        rdy             = !($urandom_range(0, 99) < pz);
        iIO_buffer_full = ($urandom_range(0, 199) < pz);
    endtask

    task automatic jump(input logic [31:0] target);
        cycle(0, 0, 0);
        iJUMP_en = 1'b1;
        iJUMP_pc = target;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; iIO_buffer_full = 1'b0;
        iMC_done = 1'b0; iMC_inst = 32'd0;
        iJUMP_en = 1'b0; iJUMP_pc = 32'd0; iIQ_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold misses from address 0, then a redirect back to 0 that hits.
        repeat (40) cycle(0, 0, 0);
        jump(32'h0);
        repeat (6) cycle(0, 0, 0);
        // Freeze for three cycles mid-stream.
        repeat (3) begin
            cycle(0, 0, 0);
            rdy = 1'b0;
        end
        repeat (10) cycle(0, 0, 0);

        // Conflict pair 0x0 / 0x100 share a line.
        jump(32'h100);
        repeat (12) cycle(0, 0, 0);
        jump(32'h0);
        repeat (12) cycle(0, 0, 0);

        // Queue held full across a fill.
        jump(32'h40);
        repeat (10) cycle(0, 100, 0);
        repeat (6) cycle(0, 0, 0);

        // Randomized traffic.
        repeat (3000) cycle(6, 20, 8);

        // Reset in the middle of an outstanding request, while frozen.
        jump(32'h8000);
        for (int i = 0; i < 200 && !oMC_en; i++) cycle(0, 0, 0);
        chk("miss_before_reset", {31'd0, oMC_en}, 32'd1);
        rst = 1'b1; rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; rdy = 1'b1; mem_cnt = 0;
        chk("rst_mc_en",   {31'd0, oMC_en}, 32'd0);
        chk("rst_mc_addr", oMC_addr, 32'd0);
        chk("rst_iq_en",   {31'd0, oIQ_en}, 32'd0);
        chk("rst_iq_pc",   oIQ_pc, 32'd0);
        chk("rst_iq_inst", oIQ_inst, 32'd0);
        repeat (30) cycle(0, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
